// File: rtl/bbox_pkg.sv
// Shared coordinate type, outline FSM states and clamp helper for the bounding-box pipeline.
package bbox_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        BOTTOM,
        LEFT,
        RIGHT,
        FILL,
        DONE
    } outline_state_t;

    function automatic coord_t clamp_coord(input coord_t c, input coord_t limit);
        return (c >= limit) ? coord_t'(limit - coord_t'(1)) : c;
    endfunction

endpackage

// File: rtl/bbox_clip.sv
// Clamps the four box coordinates into the frame and flags an empty (inverted) box.
module bbox_clip
    import bbox_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic [COORD_W-1:0] x_min_raw,
    input  logic [COORD_W-1:0] x_max_raw,
    input  logic [COORD_W-1:0] y_min_raw,
    input  logic [COORD_W-1:0] y_max_raw,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic               empty
);

    localparam coord_t X_LIMIT = coord_t'(WIDTH);
    localparam coord_t Y_LIMIT = coord_t'(HEIGHT);

    always_comb begin
        x_min = clamp_coord(x_min_raw, X_LIMIT);
        x_max = clamp_coord(x_max_raw, X_LIMIT);
        y_min = clamp_coord(y_min_raw, Y_LIMIT);
        y_max = clamp_coord(y_max_raw, Y_LIMIT);
        // Upstream reports "nothing found" as an inverted box (xMin=WIDTH, xMax=0).
        empty = (x_min > x_max) || (y_min > y_max);
    end

endmodule

// File: rtl/bbox_outline_draw.sv
// Draws a bounding-box outline into the VGA plotter, one pixel per plot handshake.
// Define BBOX_OUTLINE_FILL_EN to fill the box interior instead of drawing the side edges.
//
// state  | meaning
// IDLE   | ready, waiting for en
// TOP    | plotting row yMin, x = xMin..xMax
// BOTTOM | plotting row yMax, x = xMin..xMax
// LEFT   | plotting column xMin, y = yMin+1..yMax-1
// RIGHT  | plotting column xMax, y = yMin+1..yMax-1
// FILL   | plotting rows yMin+1..yMax-1, x = xMin..xMax (fill build only)
// DONE   | one-cycle wrap-up before IDLE
module bbox_outline_draw
    import bbox_pkg::*;
#(
    parameter int WIDTH    = 100,
    parameter int HEIGHT   = 100,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                rdy,
    input  logic [10:0]         xMin,
    input  logic [10:0]         xMax,
    input  logic [10:0]         yMin,
    input  logic [10:0]         yMax,
    input  logic [COLOUR_W-1:0] colour,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    input  logic                plot_ready,
    output logic                empty,
    output logic [15:0]         pix_count
);

    localparam coord_t ONE = coord_t'(1);
    localparam coord_t TWO = coord_t'(2);

`ifdef BBOX_OUTLINE_FILL_EN
    localparam outline_state_t MID_STATE = FILL;
`else
    localparam outline_state_t MID_STATE = LEFT;
`endif

    outline_state_t state, state_next;
    coord_t x0, x1, y0, y1, x_cur, y_cur;
    coord_t clip_x0, clip_x1, clip_y0, clip_y1;
    logic clip_empty;
    logic [COLOUR_W-1:0] col;
    logic accept, row_end, col_end, tall, flat, thin, start;

    bbox_clip #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_clip (
        .x_min_raw (xMin),
        .x_max_raw (xMax),
        .y_min_raw (yMin),
        .y_max_raw (yMax),
        .x_min     (clip_x0),
        .x_max     (clip_x1),
        .y_min     (clip_y0),
        .y_max     (clip_y1),
        .empty     (clip_empty)
    );

    assign start   = (state == IDLE) && en;
    assign accept  = vga_plot && plot_ready;
    assign row_end = (x_cur == x1);
    assign col_end = (y_cur == y1 - ONE);
    assign tall    = ((y1 - y0) >= TWO);
    assign flat    = (y1 == y0);
    assign thin    = (x1 == x0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (en) state_next = clip_empty ? DONE : TOP;
            TOP:    if (accept && row_end) state_next = flat ? DONE : BOTTOM;
            BOTTOM: if (accept && row_end) state_next = tall ? MID_STATE : DONE;
            LEFT:   if (accept && col_end) state_next = thin ? DONE : RIGHT;
            RIGHT:  if (accept && col_end) state_next = DONE;
            FILL:   if (accept && row_end && col_end) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdy      = (state == IDLE);
        vga_plot = (state == TOP) || (state == BOTTOM) || (state == LEFT) ||
                   (state == RIGHT) || (state == FILL);
    end

    // Pixel position advances only on an accepted plot, so outputs hold through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
            x_cur     <= '0;
            y_cur     <= '0;
            col       <= '0;
            empty     <= 1'b0;
            pix_count <= '0;
        end else if (start) begin
            x0        <= clip_x0;
            x1        <= clip_x1;
            y0        <= clip_y0;
            y1        <= clip_y1;
            x_cur     <= clip_x0;
            y_cur     <= clip_y0;
            col       <= colour;
            empty     <= clip_empty;
            pix_count <= '0;
        end else if (accept) begin
            pix_count <= pix_count + 16'd1;
            if (state_next != state) begin
                unique case (state_next)
                    BOTTOM:     begin x_cur <= x0; y_cur <= y1;       end
                    LEFT, FILL: begin x_cur <= x0; y_cur <= y0 + ONE; end
                    RIGHT:      begin x_cur <= x1; y_cur <= y0 + ONE; end
                    default:    ;
                endcase
            end else begin
                unique case (state)
                    TOP, BOTTOM: x_cur <= x_cur + ONE;
                    LEFT, RIGHT: y_cur <= y_cur + ONE;
                    FILL: begin
                        if (row_end) begin
                            x_cur <= x0;
                            y_cur <= y_cur + ONE;
                        end else begin
                            x_cur <= x_cur + ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vga_x      = x_cur[7:0];
    assign vga_y      = y_cur[6:0];
    assign vga_colour = col;

endmodule

// File: tb/tb_bbox_outline_draw.sv
// Self-checking bench for bbox_outline_draw: directed table, stall/reset sequences and random boxes.
module tb_bbox_outline_draw;

    localparam int W  = 100;
    localparam int H  = 100;
    localparam int CW = 3;

`ifdef BBOX_OUTLINE_FILL_EN
    localparam int CNT_A = 12, CNT_CLIP = 10000, CNT_SQ = 9;
`else
    localparam int CNT_A = 10, CNT_CLIP = 396, CNT_SQ = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic plot_ready = 1'b0;
    logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
    logic [CW-1:0] colour = '0;
    logic rdy, vga_plot, empty;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic [15:0] pix_count;

    always #5 clk = ~clk;

    bbox_outline_draw #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax), .colour(colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .plot_ready(plot_ready), .empty(empty), .pix_count(pix_count)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int x; int y; int c; } pix_t;
    pix_t got[$];
    pix_t expq[$];

    // Monitor: record accepted pixels and verify outputs hold while stalled.
    bit stall_prev = 1'b0;
    int hx, hy, hc;
    always @(negedge clk) begin
        if (rst_n && vga_plot && plot_ready)
            got.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour)});
        if (stall_prev && rst_n) begin
            chk("stall_hold_x", int'(vga_x), hx);
            chk("stall_hold_y", int'(vga_y), hy);
            chk("stall_hold_colour", int'(vga_colour), hc);
            chk("stall_hold_plot", int'(vga_plot), 1);
        end
        stall_prev = rst_n && vga_plot && !plot_ready;
        hx = int'(vga_x);
        hy = int'(vga_y);
        hc = int'(vga_colour);
    end

    function automatic int clip(input int v, input int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    // Reference: the spec's drawing order written as plain loops over the clipped box.
    task automatic build_model(input int x0r, input int x1r, input int y0r, input int y1r,
                               input int c, output int cnt, output bit emp);
        int x0, x1, y0, y1, w, h;
        x0 = clip(x0r, W); x1 = clip(x1r, W);
        y0 = clip(y0r, H); y1 = clip(y1r, H);
        expq.delete();
        emp = (x0 > x1) || (y0 > y1);
        cnt = 0;
        if (emp) return;
        for (int x = x0; x <= x1; x++) expq.push_back('{x, y0, c});
        if (y1 != y0)
            for (int x = x0; x <= x1; x++) expq.push_back('{x, y1, c});
`ifdef BBOX_OUTLINE_FILL_EN
        for (int y = y0 + 1; y <= y1 - 1; y++)
            for (int x = x0; x <= x1; x++) expq.push_back('{x, y, c});
`else
        for (int y = y0 + 1; y <= y1 - 1; y++) expq.push_back('{x0, y, c});
        if (x1 != x0)
            for (int y = y0 + 1; y <= y1 - 1; y++) expq.push_back('{x1, y, c});
`endif
        w = x1 - x0 + 1;
        h = y1 - y0 + 1;
`ifdef BBOX_OUTLINE_FILL_EN
        cnt = w * h;
`else
        cnt = (w == 1 || h == 1) ? w * h : 2 * w + 2 * h - 4;
`endif
    endtask

    function automatic bit pr(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic run_box(input string tag, input int x0r, input int x1r, input int y0r,
                           input int y1r, input int c, input int mode, input bit pulse,
                           input int t_cnt, input int t_emp);
        int m_cnt, cyc, bad, mx, my, dups;
        bit m_emp;
        bit seen[int];
        build_model(x0r, x1r, y0r, y1r, c, m_cnt, m_emp);
        cyc = 0;
        while (!rdy && cyc < 50) begin @(negedge clk); cyc++; end
        chk({tag, "_rdy_before"}, int'(rdy), 1);
        @(posedge clk); #1;
        got.delete();
        xMin = 11'(x0r); xMax = 11'(x1r); yMin = 11'(y0r); yMax = 11'(y1r);
        colour = CW'(c); en = 1'b1; plot_ready = pr(mode, 0);
        @(posedge clk); #1;
        en = 1'b0; plot_ready = pr(mode, 1);
        @(negedge clk);
        chk({tag, "_rdy_drop"}, int'(rdy), 0);
        chk({tag, "_first_plot"}, int'(vga_plot), m_emp ? 0 : 1);
        chk({tag, "_count_cleared"}, int'(pix_count), 0);
        if (!m_emp) begin
            chk({tag, "_first_x"}, int'(vga_x), expq[0].x);
            chk({tag, "_first_y"}, int'(vga_y), expq[0].y);
        end
        cyc = 1;
        while (!rdy && cyc < 25000) begin
            @(posedge clk); #1;
            cyc++;
            plot_ready = pr(mode, cyc);
            if (pulse && cyc == 3) begin
                en = 1'b1; xMin = 11'(60); xMax = 11'(70); yMin = 11'(60); yMax = 11'(70);
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
        end
        en = 1'b0;
        chk({tag, "_done_rdy"}, int'(rdy), 1);
        if (m_emp) chk({tag, "_empty_rdy_latency"}, cyc, 2);
        chk({tag, "_pix_count"}, int'(pix_count), (t_cnt >= 0) ? t_cnt : m_cnt);
        chk({tag, "_empty"}, int'(empty), (t_emp >= 0) ? t_emp : int'(m_emp));
        chk({tag, "_num_plots"}, got.size(), expq.size());
        bad = -1; mx = -1; my = -1; dups = 0;
        foreach (got[i]) begin
            if (bad < 0 && (i >= expq.size() || got[i].x != expq[i].x ||
                            got[i].y != expq[i].y || got[i].c != expq[i].c))
                bad = i;
            if (seen.exists(got[i].x * 1000 + got[i].y)) dups++;
            seen[got[i].x * 1000 + got[i].y] = 1'b1;
            if (got[i].x > mx) mx = got[i].x;
            if (got[i].y > my) my = got[i].y;
        end
        chk({tag, "_order_first_bad_index"}, bad, -1);
        chk({tag, "_duplicates"}, dups, 0);
        if (!m_emp) begin
            chk({tag, "_max_x"}, mx, clip(x1r, W));
            chk({tag, "_max_y"}, my, clip(y1r, H));
        end
        chk({tag, "_plot_idle"}, int'(vga_plot), 0);
    endtask

    typedef struct {
        string tag; int x0; int x1; int y0; int y1; int c; int mode; bit pulse; int cnt; int emp;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"box_a",    10,  13,  20,  22, 5, 0, 1'b0, CNT_A,    0};
        tbl[1] = '{"empty",   100,   0, 100,   0, 2, 0, 1'b0, 0,        1};
        tbl[2] = '{"single",    5,   5,   5,   5, 7, 0, 1'b0, 1,        0};
        tbl[3] = '{"line",      0,   7,   3,   3, 1, 0, 1'b0, 8,        0};
        tbl[4] = '{"clipped",   0, 120,   0, 110, 6, 0, 1'b0, CNT_CLIP, 0};
        tbl[5] = '{"stall",     2,   4,   2,   4, 4, 1, 1'b1, CNT_SQ,   0};

        #1;
        chk("reset_rdy", int'(rdy), 1);
        chk("reset_plot", int'(vga_plot), 0);
        chk("reset_x", int'(vga_x), 0);
        chk("reset_y", int'(vga_y), 0);
        chk("reset_colour", int'(vga_colour), 0);
        chk("reset_empty", int'(empty), 0);
        chk("reset_count", int'(pix_count), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i])
            run_box(tbl[i].tag, tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].c,
                    tbl[i].mode, tbl[i].pulse, tbl[i].cnt, tbl[i].emp);

        // Asynchronous reset in the middle of the top edge of a 50x50 box.
        @(posedge clk); #1;
        xMin = 11'd0; xMax = 11'd49; yMin = 11'd0; yMax = 11'd49; colour = 3'd3;
        en = 1'b1; plot_ready = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("abort_busy_plot", int'(vga_plot), 1);
        chk("abort_busy_x", int'(vga_x), 10);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_plot", int'(vga_plot), 0);
        chk("abort_rdy", int'(rdy), 1);
        chk("abort_count", int'(pix_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_box("post_reset", 7, 9, 7, 9, 5, 0, 1'b0, CNT_SQ, 0);

        for (int i = 0; i < 25; i++) begin
            int x0, x1, y0, y1;
            x0 = $urandom_range(0, 105);
            x1 = x0 + $urandom_range(0, 14) - 2;
            y0 = $urandom_range(0, 105);
            y1 = y0 + $urandom_range(0, 14) - 2;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            run_box("rand", x0, x1, y0, y1, $urandom_range(0, 7), 2, 1'b0, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bbox_outline_draw.md
Name: bbox_outline_draw

Overview:
- Downstream consumer of the bounding-box stage. Takes the four box coordinates it produces (xMin, xMax, yMin, yMax).
- Draws the rectangle outline into the VGA framebuffer plotter, one pixel per accepted plot handshake.
- Same en/rdy start protocol as the other image-processing stages.
- Handles empty boxes (no qualifying pixel found) and out-of-frame coordinates.

Parameters:
- WIDTH, 100, image width in pixels; x range 0..WIDTH-1.
- HEIGHT, 100, image height in pixels; y range 0..HEIGHT-1.
- COLOUR_W, 3, width of plot colour.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  idle/ready for a new box
- xMin  input  11  box left, latched at start
- xMax  input  11  box right, latched at start
- yMin  input  11  box top, latched at start
- yMax  input  11  box bottom, latched at start
- colour  input  COLOUR_W  outline colour, latched at start
- vga_x  output  8  plot x
- vga_y  output  7  plot y
- vga_colour  output  COLOUR_W  plot colour
- vga_plot  output  1  plot request valid
- plot_ready  input  1  plotter accepts the current pixel this cycle
- empty  output  1  last box was empty; valid while rdy=1
- pix_count  output  16  pixels plotted for the last box

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, rdy=1, vga_plot=0.
  - vga_x, vga_y, vga_colour, empty and pix_count are all 0.
- Start:
  - Accepted on a rising edge where rdy=1 and en=1. Coordinates and colour are latched; rdy drops next cycle.
  - en while busy is ignored.
- Clipping at latch time:
  - Any x >= WIDTH is clamped to WIDTH-1; any y >= HEIGHT is clamped to HEIGHT-1.
- Empty box:
  - Defined as xMin > xMax or yMin > yMax, checked after clipping. This covers the upstream reset values xMin=WIDTH, xMax=0.
  - FSM goes to DONE with no plots. rdy=1 two cycles after the start edge, empty=1, pix_count=0.
- States, in this order: IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE.
  - TOP: y=yMin, x runs xMin..xMax.
  - BOTTOM: y=yMax, x runs xMin..xMax. Skipped if yMax==yMin.
  - LEFT: x=xMin, y runs yMin+1..yMax-1. Skipped if yMax-yMin<2.
  - RIGHT: x=xMax, same y range as LEFT. Skipped if xMax==xMin or yMax-yMin<2.
  - DONE: returns to IDLE after one cycle; rdy=1 in IDLE.
- Latency: the first vga_plot is asserted the cycle after the start edge.
- Plot handshake:
  - vga_plot, vga_x, vga_y and vga_colour are registered and held stable until a cycle with vga_plot=1 and plot_ready=1.
  - On that cycle the next pixel is presented on the following cycle. Sustained rate is 1 pixel/cycle with no bubbles between edges.
  - vga_plot deasserts in the cycle after the final accept.
- Pixel count: pix_count increments on each accept and is cleared at start.
  - For box width w and height h (after clipping), the final count is w*h if w==1 or h==1, else 2w+2h-4.
  - No pixel is emitted twice.
- Reset mid-operation aborts immediately: vga_plot=0, rdy=1. No partial state survives.
- Outputs vga_x/vga_y are the low 8/7 bits of the internal 11-bit counters. Widths are guaranteed sufficient by WIDTH<=256 and HEIGHT<=128.

Optional Feature:
- Macro BBOX_OUTLINE_FILL_EN.
- Defined: LEFT/RIGHT are replaced by state FILL, which covers rows yMin+1..yMax-1 with x running xMin..xMax. Final pix_count is w*h for every non-empty box.
- Undefined: outline only, as above.

Decomposition:
- Package bbox_pkg:
  - COORD_W=11
  - typedef coord_t (logic [COORD_W-1:0])
  - typedef enum outline_state_t (IDLE, TOP, BOTTOM, LEFT, RIGHT, FILL, DONE)
  - function clamp_coord
- The bounding-box stage shares coord_t from the same package.
- Sub-module bbox_clip: combinational clamp plus empty detect for the four coordinates, instantiated once at the latch point.

Test Plan:
- Box x 10..13, y 20..22, plot_ready tied 1 -> exactly 10 plots. Order:
  - (10..13,20)
  - (10..13,22)
  - (10,21)
  - (13,21)
  - then pix_count=10, empty=0, rdy=1.
- xMin=100, xMax=0, yMin=100, yMax=0 (upstream reset values) -> zero plots, empty=1, pix_count=0, rdy back within 2 cycles.
- Single pixel box (5,5)-(5,5) -> one plot at (5,5), pix_count=1. Line box x 0..7, y 3 -> 8 plots, none duplicated.
- Box 0..120 x 0..110 with WIDTH=HEIGHT=100 -> clipped to 0..99 x 0..99, pix_count=396, max vga_x=99, max vga_y=99.
- plot_ready toggling 1-0-0-1 on box 2..4 x 2..4 -> x/y/colour stable while stalled, pix_count=8, en pulses while busy ignored.
- rst_n pulled low mid-TOP edge of a 50x50 box -> vga_plot=0 and rdy=1 asynchronously. A new start after release draws the full new box.
